mod_reduce_seq: RTL and testbench
=================================

MOD_REDUCE_SEQ -- requirements
Module: mod_reduce_seq

Interface
REQ-001 SHALL have parameter MOD, default 4051, the modulus; the legal range is 2 <= MOD < 2^W.
REQ-002 SHALL have parameter IN_W, default 400, the operand width in bits.
REQ-003 SHALL have parameter CHUNK, default 6, the operand bits consumed per cycle; the legal range is 1..8.
REQ-004 SHALL have parameter W, default 12, the result width; W = ceil(log2(MOD)).
REQ-005 SHALL define localparam NCH = ceil(IN_W/CHUNK), the chunk count (67 at defaults).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; every flop updates on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit: the operand is presented.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-010 SHALL have port in_data, input, IN_W bits: the unsigned operand X.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is available.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port out_data, output, W bits: X mod MOD.
REQ-014 SHALL have port busy, output, 1 bit: high while in RUN.

Function
REQ-015 SHALL implement three FSM states: IDLE, RUN and DONE.
REQ-016 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready), and drive out_valid = (state==DONE).
REQ-017 SHALL define acceptance as in_valid & in_ready at a rising edge; on acceptance it latches in_data, zero-extended at the MSB to NCH*CHUNK bits.
REQ-018 SHALL, on acceptance, clear acc to 0, load the chunk index to NCH-1 and enter RUN.
REQ-019 SHALL, in each RUN cycle, compute acc <= (acc*2^CHUNK + chunk[idx]) mod MOD, consuming chunks MSB-first (Horner order).
REQ-020 SHALL hold acc in W bits; the intermediate value is < MOD*2^CHUNK, held in W+CHUNK bits.
REQ-021 SHALL perform the reduction in one cycle with a CHUNK-step conditional-subtract ladder (MOD<<k, k = CHUNK-1 down to 0), with no divider and no wrap/truncation of the intermediate value.
REQ-022 SHALL decrement the index each RUN cycle; when the chunk with idx==0 is processed, the FSM enters DONE.
REQ-023 SHALL assert out_valid exactly NCH rising edges after the acceptance edge (67 cycles at defaults).
REQ-024 SHALL hold out_data stable in DONE until out_valid & out_ready, after which it returns to IDLE.
REQ-025 SHALL accept a new operand in DONE when out_ready=1 and in_valid=1 in the same cycle: the result is retired and the new operand is latched on the same edge, going directly to RUN with no bubble.
REQ-026 SHALL ignore in_valid while in RUN (in_ready=0), and SHALL NOT sample in_data outside acceptance.
REQ-027 SHALL always produce out_data < MOD.
REQ-028 SHALL drive out_data to 0 while out_valid=0.
REQ-029 SHALL, for the degenerate case IN_W <= CHUNK, set NCH=1 and assert out_valid one edge after acceptance.

Reset
REQ-030 SHALL, when rst=1 at a rising edge, force state to IDLE, acc to 0, the index to 0 and the operand register to 0.
REQ-031 SHALL produce these reset output values: in_ready=1, out_valid=0, out_data=0, busy=0.
REQ-032 SHALL, on reset during RUN or DONE, abort the transaction and drop the result; no out_valid is produced for it.
REQ-033 SHALL give rst priority over a simultaneous acceptance or retirement; the operand is not latched.

Verification
REQ-034 SHALL pass basic values: X=0 -> 0; X=4050 -> 4050; X=4051 -> 0; X=4096 -> 45; X=2^24 -> 2025; each with out_valid rising exactly 67 cycles after acceptance.
REQ-035 SHALL pass the all-ones test: X=2^400-1 -> out_data equal to the reference model (2^400-1) mod 4051; also 500 random 400-bit X checked against the model, with random out_ready backpressure.
REQ-036 SHALL pass back-to-back operation: in_valid held high with out_ready=1 -> consecutive results every 67 cycles, with no idle cycle between transactions.
REQ-037 SHALL pass backpressure: out_ready=0 for 20 cycles in DONE -> out_data and out_valid stable, and in_ready=0 throughout.
REQ-038 SHALL pass reset mid-RUN: rst pulsed at cycle 30 of RUN -> idle outputs on the next cycle, no stale out_valid, and the next operand (4096) returns 45.
REQ-039 SHALL pass a parameter sweep: MOD=13, CHUNK=3, IN_W=10, X=1023 -> 9 after NCH=4 cycles; MOD=4051, CHUNK=1 -> latency 400.

Source files
------------

// File: rtl/mod_reduce_seq.sv
// Sequential X mod MOD reducer: Horner evaluation of the operand, CHUNK bits per cycle,
// with a conditional-subtract ladder keeping the running remainder below MOD.
module mod_reduce_seq #(
    parameter int MOD   = 4051,
    parameter int IN_W  = 400,
    parameter int CHUNK = 6,
    parameter int W     = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic            busy
);

    localparam int NCH   = (IN_W + CHUNK - 1) / CHUNK;
    localparam int PW    = NCH * CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int XW    = W + CHUNK;
    localparam logic [XW-1:0]    MOD_X    = XW'(MOD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} StateT;

    StateT             r_state;
    StateT             w_nextState;
    logic [W-1:0]      r_acc;
    logic [IDX_W-1:0]  r_idx;
    logic [PW-1:0]     r_operand;
    logic              w_accept;
    logic [CHUNK-1:0]  w_chunk;
    logic [XW-1:0]     w_ladder;
    logic [W-1:0]      w_accNext;

    assign w_accept = in_valid & in_ready;

    // The operand shifts left each RUN cycle, so the chunk being consumed is always the top one.
    assign w_chunk = r_operand[PW-1 -: CHUNK];

    // acc*2^CHUNK + chunk is below MOD*2^CHUNK, so one subtract attempt per power of two suffices.
    always_comb begin
        w_ladder = {r_acc, w_chunk};
        for (int k = CHUNK - 1; k >= 0; k--) begin
            if (w_ladder >= (MOD_X << k)) begin
                w_ladder = w_ladder - (MOD_X << k);
            end
        end
        w_accNext = w_ladder[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (in_valid) w_nextState = RUN;
            RUN:  if (r_idx == '0) w_nextState = DONE;
            DONE: if (out_ready) w_nextState = in_valid ? RUN : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
        out_valid = (r_state == DONE);
        busy      = (r_state == RUN);
        out_data  = (r_state == DONE) ? r_acc : '0;
    end

    // Datapath: acc is frozen outside RUN, which keeps the result stable while DONE waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_idx     <= '0;
            r_operand <= '0;
        end else if (w_accept) begin
            r_acc     <= '0;
            r_idx     <= LAST_IDX;
            r_operand <= PW'(in_data);
        end else if (r_state == RUN) begin
            r_acc     <= w_accNext;
            r_operand <= r_operand << CHUNK;
            if (r_idx != '0) begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Self-checking bench for mod_reduce_seq: directed and random operands against a wide-arithmetic
// modulo reference, plus backpressure, back-to-back, reset and parameter-sweep instances.
module tb_mod_reduce_seq;

    localparam int MOD  = 4051;
    localparam int IN_W = 400;
    localparam int W    = 12;
    localparam int NCH  = 67;

    logic            clk;
    logic            rst;
    logic            inValid, inReady, outValid, outReady, busy;
    logic [IN_W-1:0] inData;
    logic [W-1:0]    outData;

    logic            sInValid, sInReady, sOutValid, sBusy;
    logic [9:0]      sInData;
    logic [3:0]      sOutData;
    logic            cInValid, cInReady, cOutValid, cBusy;
    logic [399:0]    cInData;
    logic [11:0]     cOutData;
    logic            dInValid, dInReady, dOutValid, dBusy;
    logic [3:0]      dInData;
    logic [3:0]      dOutData;
    logic            auxOutReady;

    int assertCount;
    int failCount;

    mod_reduce_seq dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData), .busy(busy)
    );

    mod_reduce_seq #(.MOD(13), .IN_W(10), .CHUNK(3), .W(4)) dutSmall (
        .clk(clk), .rst(rst), .in_valid(sInValid), .in_ready(sInReady), .in_data(sInData),
        .out_valid(sOutValid), .out_ready(auxOutReady), .out_data(sOutData), .busy(sBusy)
    );

    mod_reduce_seq #(.MOD(4051), .IN_W(400), .CHUNK(1), .W(12)) dutChunk1 (
        .clk(clk), .rst(rst), .in_valid(cInValid), .in_ready(cInReady), .in_data(cInData),
        .out_valid(cOutValid), .out_ready(auxOutReady), .out_data(cOutData), .busy(cBusy)
    );

    mod_reduce_seq #(.MOD(13), .IN_W(4), .CHUNK(6), .W(4)) dutDegen (
        .clk(clk), .rst(rst), .in_valid(dInValid), .in_ready(dInReady), .in_data(dInData),
        .out_valid(dOutValid), .out_ready(auxOutReady), .out_data(dOutData), .busy(dBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain wide-integer modulo of the whole operand.
    function automatic int modRef(input logic [399:0] x, input int m);
        logic [399:0] wide;
        logic [399:0] rem;
        wide = 400'(m);
        rem  = x % wide;
        return int'(rem[31:0]);
    endfunction

    function automatic logic [399:0] randX();
        logic [415:0] t;
        for (int j = 0; j < 13; j++) t[j*32 +: 32] = $urandom();
        return t[399:0];
    endfunction

    function automatic logic auxReady(input int sel);
        case (sel)
            0: return sInReady;
            1: return cInReady;
            default: return dInReady;
        endcase
    endfunction

    function automatic logic auxValid(input int sel);
        case (sel)
            0: return sOutValid;
            1: return cOutValid;
            default: return dOutValid;
        endcase
    endfunction

    function automatic logic auxBusy(input int sel);
        case (sel)
            0: return sBusy;
            1: return cBusy;
            default: return dBusy;
        endcase
    endfunction

    function automatic logic [11:0] auxData(input int sel);
        case (sel)
            0: return {8'b0, sOutData};
            1: return cOutData;
            default: return {8'b0, dOutData};
        endcase
    endfunction

    task automatic applyStimulus(input logic [399:0] x);
        int guard;
        guard = 0;
        while (inReady !== 1'b1 && guard < 200) begin
            step();
            guard++;
        end
        checkOutput("accept ready", inReady, 1);
        inData  = x;
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        checkOutput("busy after accept", busy, 1);
        checkOutput("data zero in RUN", outData, 0);
    endtask

    task automatic waitResult(output int cycles);
        cycles = 0;
        while (outValid !== 1'b1 && cycles < 1000) begin
            step();
            cycles++;
        end
    endtask

    task automatic runOne(input logic [399:0] x, input int expRes, input string tag, input int holdCycles);
        int cycles;
        applyStimulus(x);
        waitResult(cycles);
        checkOutput({tag, " latency"}, cycles, NCH);
        checkOutput({tag, " result"}, outData, expRes);
        repeat (holdCycles) begin
            step();
            checkOutput({tag, " hold"}, outData, expRes);
        end
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        checkOutput({tag, " retired"}, outValid, 0);
    endtask

    task automatic runAux(input int sel, input logic [399:0] x, input int expLat, input int expRes,
                          input string tag);
        int cycles;
        checkOutput({tag, " ready"}, auxReady(sel), 1);
        case (sel)
            0: begin sInData = x[9:0]; sInValid = 1'b1; end
            1: begin cInData = x;      cInValid = 1'b1; end
            default: begin dInData = x[3:0]; dInValid = 1'b1; end
        endcase
        step();
        sInValid = 1'b0;
        cInValid = 1'b0;
        dInValid = 1'b0;
        checkOutput({tag, " busy"}, auxBusy(sel), 1);
        cycles = 0;
        while (auxValid(sel) !== 1'b1 && cycles < 1000) begin
            step();
            cycles++;
        end
        checkOutput({tag, " latency"}, cycles, expLat);
        checkOutput({tag, " result"}, auxData(sel), expRes);
        step();
        checkOutput({tag, " retired"}, auxValid(sel), 0);
    endtask

    initial begin
        logic [399:0] x;
        logic [399:0] one;
        logic [399:0] allOnes;
        logic [399:0] cur;
        logic [399:0] nxt;
        int cycles;
        int seen;

        assertCount = 0;
        failCount   = 0;
        rst = 1'b1;
        inValid = 1'b0; inData = '0; outReady = 1'b0;
        sInValid = 1'b0; sInData = '0;
        cInValid = 1'b0; cInData = '0;
        dInValid = 1'b0; dInData = '0;
        auxOutReady = 1'b1;
        one = 400'd1;
        allOnes = '1;

        repeat (3) step();
        checkOutput("reset in_ready", inReady, 1);
        checkOutput("reset out_valid", outValid, 0);
        checkOutput("reset out_data", outData, 0);
        checkOutput("reset busy", busy, 0);
        rst = 1'b0;
        step();

        $display("[TB] basic values");
        runOne(400'd0, 0, "x=0", 0);
        runOne(400'd4050, 4050, "x=4050", 1);
        runOne(400'd4051, 0, "x=4051", 0);
        runOne(400'd4096, 45, "x=4096", 2);
        runOne(one << 24, 2025, "x=2^24", 0);
        runOne(allOnes, modRef(allOnes, MOD), "all ones", 0);

        $display("[TB] random operands with backpressure");
        for (int i = 0; i < 500; i++) begin
            x = randX();
            runOne(x, modRef(x, MOD), "random", int'($urandom_range(0, 3)));
        end

        $display("[TB] back-to-back");
        cur = randX();
        inData = cur;
        inValid = 1'b1;
        outReady = 1'b1;
        step();
        for (int t = 0; t < 4; t++) begin
            inData = randX();
            cycles = 0;
            while (outValid !== 1'b1 && cycles < 1000) begin
                step();
                cycles++;
            end
            checkOutput("b2b latency", cycles, NCH);
            checkOutput("b2b result", outData, modRef(cur, MOD));
            checkOutput("b2b in_ready", inReady, 1);
            nxt = randX();
            if (t == 3) inValid = 1'b0;
            inData = nxt;
            step();
            checkOutput("b2b busy", busy, (t < 3) ? 1 : 0);
            cur = nxt;
        end
        outReady = 1'b0;

        $display("[TB] backpressure");
        applyStimulus(400'd4096);
        waitResult(cycles);
        checkOutput("bp latency", cycles, NCH);
        inValid = 1'b1;
        inData = randX();
        for (int i = 0; i < 20; i++) begin
            step();
            checkOutput("bp valid", outValid, 1);
            checkOutput("bp data", outData, 45);
            checkOutput("bp in_ready", inReady, 0);
        end
        inValid = 1'b0;
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        checkOutput("bp retired", outValid, 0);
        checkOutput("bp idle ready", inReady, 1);

        $display("[TB] reset mid-RUN");
        applyStimulus(randX());
        repeat (29) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrun in_ready", inReady, 1);
        checkOutput("midrun out_valid", outValid, 0);
        checkOutput("midrun busy", busy, 0);
        checkOutput("midrun out_data", outData, 0);
        seen = 0;
        repeat (80) begin
            step();
            if (outValid !== 1'b0) seen++;
        end
        checkOutput("no stale valid", seen, 0);
        runOne(400'd4096, 45, "post reset", 0);

        $display("[TB] reset priority over acceptance");
        inData = 400'd4096;
        inValid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        inValid = 1'b0;
        checkOutput("rst prio busy", busy, 0);
        checkOutput("rst prio ready", inReady, 1);
        step();
        checkOutput("rst prio still idle", busy, 0);

        $display("[TB] parameter sweep");
        runAux(0, 400'd1023, 4, 9, "mod13 x=1023");
        for (int i = 0; i < 20; i++) begin
            x = 400'($urandom_range(0, 1023));
            runAux(0, x, 4, modRef(x, 13), "mod13 random");
        end
        for (int v = 0; v < 16; v++) begin
            x = 400'(v);
            runAux(2, x, 1, v % 13, "degenerate");
        end
        runAux(1, 400'd4096, 400, 45, "chunk1 x=4096");
        runAux(1, allOnes, 400, modRef(allOnes, MOD), "chunk1 all ones");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
